// File: rtl/trb_mem_arbiter.sv
// Arbiter/sequencer for the single-port trace buffer RAM: logger swaps vs. interface reads/writes.
// Every access runs IDLE -> ACCESS -> RESP, so one access completes per three cycles.
module trb_mem_arbiter #(
    parameter int TRB_WIDTH = 32,
    parameter int TRB_DEPTH = 1024,
    localparam int AW = $clog2(TRB_DEPTH)
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    input  logic                 LOG_REQ_I,
    input  logic [AW-1:0]        LOG_PTR_I,
    input  logic [TRB_WIDTH-1:0] LOG_DATA_I,
    output logic                 LOG_TURN_O,
    output logic [TRB_WIDTH-1:0] LOG_DATA_O,
    input  logic                 IF_REQ_I,
    input  logic                 IF_WE_I,
    input  logic [AW-1:0]        IF_PTR_I,
    input  logic [TRB_WIDTH-1:0] IF_DATA_I,
    output logic                 IF_ACK_O,
    output logic [TRB_WIDTH-1:0] IF_DATA_O,
    output logic                 MEM_EN_O,
    output logic                 MEM_WE_O,
    output logic [AW-1:0]        MEM_ADDR_O,
    output logic [TRB_WIDTH-1:0] MEM_WDATA_O,
    input  logic [TRB_WIDTH-1:0] MEM_RDATA_I,
    output logic                 BUSY_O
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_last_log;
    logic                   r_own_log;
    logic [AW-1:0]          r_addr;
    logic [TRB_WIDTH-1:0]   r_wdata;
    logic                   r_we;
    logic                   r_mem_en;
    logic                   r_busy;
    logic                   r_log_turn;
    logic                   r_if_ack;
    logic [TRB_WIDTH-1:0]   r_log_data;
    logic [TRB_WIDTH-1:0]   r_if_data;

    logic                   w_grant_log;
    logic                   w_grant_if;

    // On contention the requester that did not win last time goes first.
    assign w_grant_log = LOG_REQ_I && (!IF_REQ_I || !r_last_log);
    assign w_grant_if  = IF_REQ_I && !w_grant_log;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state    <= ST_IDLE;
            r_last_log <= 1'b0;
            r_own_log  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_mem_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_log_turn <= 1'b0;
            r_if_ack   <= 1'b0;
            r_log_data <= '0;
            r_if_data  <= '0;
        end else begin
            r_log_turn <= 1'b0;
            r_if_ack   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_log || w_grant_if) begin
                        r_own_log  <= w_grant_log;
                        r_last_log <= w_grant_log;
                        r_addr     <= w_grant_log ? LOG_PTR_I : IF_PTR_I;
                        r_wdata    <= w_grant_log ? LOG_DATA_I : IF_DATA_I;
                        r_we       <= w_grant_log ? 1'b1 : IF_WE_I;
                        r_mem_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_en   <= 1'b0;
                    r_we       <= 1'b0;
                    r_log_turn <= r_own_log;
                    r_if_ack   <= !r_own_log;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_own_log) r_log_data <= MEM_RDATA_I;
                    else           r_if_data  <= MEM_RDATA_I;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_we     <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives in RESP, the same cycle as the strobe, so it is forwarded
    // while the strobe is high and held from the register afterwards.
    assign LOG_DATA_O  = r_log_turn ? MEM_RDATA_I : r_log_data;
    assign IF_DATA_O   = r_if_ack ? MEM_RDATA_I : r_if_data;
    assign LOG_TURN_O  = r_log_turn;
    assign IF_ACK_O    = r_if_ack;
    assign MEM_EN_O    = r_mem_en;
    assign MEM_WE_O    = r_we;
    assign MEM_ADDR_O  = r_addr;
    assign MEM_WDATA_O = r_wdata;
    assign BUSY_O      = r_busy;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Directed + randomized bench for trb_mem_arbiter with a read-first RAM model and a
// transaction-level reference (word store + alternating-priority rule).
module tb_trb_mem_arbiter;
    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          CLK_I = 1'b0;
    logic          RST_NI;
    logic          LOG_REQ_I;
    logic [AW-1:0] LOG_PTR_I;
    logic [W-1:0]  LOG_DATA_I;
    logic          LOG_TURN_O;
    logic [W-1:0]  LOG_DATA_O;
    logic          IF_REQ_I;
    logic          IF_WE_I;
    logic [AW-1:0] IF_PTR_I;
    logic [W-1:0]  IF_DATA_I;
    logic          IF_ACK_O;
    logic [W-1:0]  IF_DATA_O;
    logic          MEM_EN_O;
    logic          MEM_WE_O;
    logic [AW-1:0] MEM_ADDR_O;
    logic [W-1:0]  MEM_WDATA_O;
    logic [W-1:0]  MEM_RDATA_I;
    logic          BUSY_O;

    trb_mem_arbiter #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI),
        .LOG_REQ_I(LOG_REQ_I), .LOG_PTR_I(LOG_PTR_I), .LOG_DATA_I(LOG_DATA_I),
        .LOG_TURN_O(LOG_TURN_O), .LOG_DATA_O(LOG_DATA_O),
        .IF_REQ_I(IF_REQ_I), .IF_WE_I(IF_WE_I), .IF_PTR_I(IF_PTR_I), .IF_DATA_I(IF_DATA_I),
        .IF_ACK_O(IF_ACK_O), .IF_DATA_O(IF_DATA_O),
        .MEM_EN_O(MEM_EN_O), .MEM_WE_O(MEM_WE_O), .MEM_ADDR_O(MEM_ADDR_O),
        .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(MEM_RDATA_I), .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Single-port RAM macro: 1-cycle read latency, read-first.
    logic [W-1:0] ram [D];
    always @(posedge CLK_I) begin
        if (MEM_EN_O) begin
            MEM_RDATA_I <= ram[MEM_ADDR_O];
            if (MEM_WE_O) ram[MEM_ADDR_O] <= MEM_WDATA_O;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [W-1:0] ref_mem [int];
    bit m_prio_log;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_turn"},  64'(LOG_TURN_O),  64'd0);
        chk({tag, "_ack"},   64'(IF_ACK_O),    64'd0);
        chk({tag, "_en"},    64'(MEM_EN_O),    64'd0);
        chk({tag, "_we"},    64'(MEM_WE_O),    64'd0);
        chk({tag, "_addr"},  64'(MEM_ADDR_O),  64'd0);
        chk({tag, "_wdata"}, 64'(MEM_WDATA_O), 64'd0);
        chk({tag, "_ldata"}, 64'(LOG_DATA_O),  64'd0);
        chk({tag, "_idata"}, 64'(IF_DATA_O),   64'd0);
        chk({tag, "_busy"},  64'(BUSY_O),      64'd0);
    endtask

    // Called in an IDLE cycle where the given requester is expected to win.
    task automatic serve(input bit is_log, input bit keep, input bit scramble, input bit if_pulse);
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic [W-1:0]  old;
        logic          w;
        bit            known;
        a     = is_log ? LOG_PTR_I : IF_PTR_I;
        d     = is_log ? LOG_DATA_I : IF_DATA_I;
        w     = is_log ? 1'b1 : IF_WE_I;
        known = ref_mem.exists(int'(a));
        old   = known ? ref_mem[int'(a)] : '0;
        m_prio_log = !is_log;
        step();
        if (scramble) begin
            LOG_PTR_I  = ~LOG_PTR_I;
            LOG_DATA_I = ~LOG_DATA_I;
        end
        if (if_pulse) IF_REQ_I = 1'b1;
        chk("acc_en",    64'(MEM_EN_O),    64'd1);
        chk("acc_we",    64'(MEM_WE_O),    64'(w));
        chk("acc_addr",  64'(MEM_ADDR_O),  64'(a));
        if (w) chk("acc_wdata", 64'(MEM_WDATA_O), 64'(d));
        chk("acc_busy",  64'(BUSY_O),      64'd1);
        chk("acc_strb",  64'({LOG_TURN_O, IF_ACK_O}), 64'd0);
        step();
        if (if_pulse) IF_REQ_I = 1'b0;
        chk("rsp_turn",  64'(LOG_TURN_O),  64'(is_log));
        chk("rsp_ack",   64'(IF_ACK_O),    64'(!is_log));
        chk("rsp_en",    64'({MEM_EN_O, MEM_WE_O}), 64'd0);
        chk("rsp_busy",  64'(BUSY_O),      64'd1);
        if (known && is_log)        chk("rsp_ldata", 64'(LOG_DATA_O), 64'(old));
        if (known && !is_log && !w) chk("rsp_idata", 64'(IF_DATA_O),  64'(old));
        if (w) ref_mem[int'(a)] = d;
        if (!keep) begin
            if (is_log) LOG_REQ_I = 1'b0;
            else        IF_REQ_I  = 1'b0;
        end
        step();
        chk("idl_busy",  64'(BUSY_O),      64'd0);
        chk("idl_strb",  64'({LOG_TURN_O, IF_ACK_O}), 64'd0);
        chk("idl_en",    64'(MEM_EN_O),    64'd0);
        if (known && is_log) chk("hold_ldata", 64'(LOG_DATA_O), 64'(old));
    endtask

    task automatic if_access(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        IF_REQ_I = 1'b1; IF_WE_I = we; IF_PTR_I = a; IF_DATA_I = d;
        serve(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RST_NI = 1'b0;
        LOG_REQ_I = 0; LOG_PTR_I = '0; LOG_DATA_I = '0;
        IF_REQ_I = 0; IF_WE_I = 0; IF_PTR_I = '0; IF_DATA_I = '0;
        m_prio_log = 1'b1;
        step(); step();
        chk_all_zero("rst");
        RST_NI = 1'b1;
        step();
        chk("post_rst_busy", 64'(BUSY_O), 64'd0);

        // Interface write then read at the top address.
        if_access(1'b1, 10'd1023, 32'hDEADBEEF);
        if_access(1'b0, 10'd1023, 32'h0);
        chk("rd1023", 64'(IF_DATA_O), 64'h0000_0000_DEAD_BEEF);

        // Logger swap with payload scrambled during ACCESS; then an interface
        // read pulse during ACCESS must not produce an access.
        if_access(1'b1, 10'd5, 32'hAAAA0000);
        LOG_REQ_I = 1'b1; LOG_PTR_I = 10'd5; LOG_DATA_I = 32'h12345678;
        serve(1'b1, 1'b0, 1'b1, 1'b1);
        chk("swap_old", 64'(LOG_DATA_O), 64'h0000_0000_AAAA_0000);
        step();
        chk("drop_busy", 64'(BUSY_O), 64'd0);
        chk("drop_ack",  64'(IF_ACK_O), 64'd0);
        if_access(1'b0, 10'd5, 32'h0);
        chk("swap_new", 64'(IF_DATA_O), 64'h0000_0000_1234_5678);

        // Continuous contention from reset: L, I, L, I back to back.
        RST_NI = 1'b0;
        LOG_REQ_I = 1'b1; LOG_PTR_I = 10'd5;  LOG_DATA_I = 32'h11111111;
        IF_REQ_I  = 1'b1; IF_WE_I = 1'b0; IF_PTR_I = 10'd1023;
        step();
        RST_NI = 1'b1; m_prio_log = 1'b1;
        serve(1'b1, 1'b1, 1'b0, 1'b0);
        serve(1'b0, 1'b1, 1'b0, 1'b0);
        serve(1'b1, 1'b1, 1'b0, 1'b0);
        serve(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a logger swap; logger must win again afterwards.
        LOG_PTR_I = 10'd200;
        step();
        chk("abort_en", 64'(MEM_EN_O), 64'd1);
        RST_NI = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        RST_NI = 1'b1; m_prio_log = 1'b1;
        ref_mem.delete(200);
        LOG_PTR_I = 10'd7; LOG_DATA_I = 32'h0BADF00D;
        serve(1'b1, 1'b0, 1'b0, 1'b0);
        serve(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized rounds on a small preloaded address window.
        for (int i = 0; i < 16; i++) if_access(1'b1, AW'(i), $urandom);
        for (int r = 0; r < 40; r++) begin
            LOG_REQ_I = 1'($urandom_range(0, 1));
            IF_REQ_I  = !LOG_REQ_I | 1'($urandom_range(0, 1));
            LOG_PTR_I = AW'($urandom_range(0, 15)); LOG_DATA_I = $urandom;
            IF_PTR_I  = AW'($urandom_range(0, 15)); IF_DATA_I  = $urandom;
            IF_WE_I   = 1'($urandom_range(0, 1));
            while (LOG_REQ_I || IF_REQ_I)
                serve((LOG_REQ_I && IF_REQ_I) ? m_prio_log : LOG_REQ_I, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
